// File: rtl/rs_multi_cdb_if.sv
// rs_multi_cdb_if: dispatch, CDB broadcast and issue handshake bundle.
// master = decoder/CDB/FU side, slave = reservation station.
interface rs_multi_cdb_if #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int OP_W  = 11,
    parameter int CDB_N = 2,
    parameter int CNT_W = 5
);
    logic                   in_valid;
    logic [XLEN-1:0]        in_pc;
    logic                   in_is_short;
    logic [OP_W-1:0]        in_op;
    logic [XLEN-1:0]        in_imm;
    logic                   in_rdy1;
    logic                   in_rdy2;
    logic [ROB_W-1:0]       in_Q1;
    logic [ROB_W-1:0]       in_Q2;
    logic [XLEN-1:0]        in_V1;
    logic [XLEN-1:0]        in_V2;
    logic [ROB_W-1:0]       in_Qdest;
    logic                   rs_full;
    logic [CNT_W-1:0]       count;
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*ROB_W-1:0] cdb_tag;
    logic [CDB_N*XLEN-1:0]  cdb_value;
    logic                   iss_valid;
    logic                   iss_ready;
    logic [XLEN-1:0]        iss_pc;
    logic                   iss_is_short;
    logic [OP_W-1:0]        iss_op;
    logic [XLEN-1:0]        iss_imm;
    logic [XLEN-1:0]        iss_V1;
    logic [XLEN-1:0]        iss_V2;
    logic [ROB_W-1:0]       iss_Qdest;

    modport master (
        output in_valid, in_pc, in_is_short, in_op, in_imm,
        output in_rdy1, in_rdy2, in_Q1, in_Q2, in_V1, in_V2, in_Qdest,
        output cdb_valid, cdb_tag, cdb_value, iss_ready,
        input  rs_full, count, iss_valid, iss_pc, iss_is_short,
        input  iss_op, iss_imm, iss_V1, iss_V2, iss_Qdest
    );

    modport slave (
        input  in_valid, in_pc, in_is_short, in_op, in_imm,
        input  in_rdy1, in_rdy2, in_Q1, in_Q2, in_V1, in_V2, in_Qdest,
        input  cdb_valid, cdb_tag, cdb_value, iss_ready,
        output rs_full, count, iss_valid, iss_pc, iss_is_short,
        output iss_op, iss_imm, iss_V1, iss_V2, iss_Qdest
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: reservation station with N CDB wakeup ports, oldest-first
// select via an age matrix, and a registered valid/ready issue stage.
// Ports: clk_in, rst_in (async, active-high), rdy_in (global enable),
// rob_clear (flush), bus (dispatch in, rs_full/count, CDB in, issue out).
module rs_multi_cdb #(
    parameter int RS_SIZE     = 16,
    parameter int ROB_W       = 4,
    parameter int CDB_N       = 2,
    parameter int XLEN        = 32,
    parameter int OP_W        = 11,
    parameter int FULL_MARGIN = 1
) (
    input logic           clk_in,
    input logic           rst_in,
    input logic           rdy_in,
    input logic           rob_clear,
    rs_multi_cdb_if.slave bus
);
    localparam int CNT_W = $clog2(RS_SIZE + 1);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(RS_SIZE - FULL_MARGIN);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             is_short;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  imm;
        logic [ROB_W-1:0] qdest;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
    } iss_t;

    typedef struct packed {
        iss_t             p;
        logic             rdy1;
        logic             rdy2;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
    } ent_t;

    ent_t               ent_q [RS_SIZE];
    ent_t               ent_d [RS_SIZE];
    logic [RS_SIZE-1:0] older_q [RS_SIZE];
    logic [RS_SIZE-1:0] older_d [RS_SIZE];
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               iss_valid_q, iss_valid_d;
    iss_t               iss_q, iss_d;

    logic [RS_SIZE-1:0] ready, win;
    logic [IDX_W-1:0]   win_idx, free_idx;
    logic               alloc, load;
    logic [XLEN:0]      byp1, byp2;
    logic [XLEN:0]      wk1 [RS_SIZE];
    logic [XLEN:0]      wk2 [RS_SIZE];
    ent_t               new_ent;

    // {hit, value}; loop runs high-to-low so the lowest matching port wins
    function automatic logic [XLEN:0] snoop(
        input logic [ROB_W-1:0]       tag,
        input logic [CDB_N-1:0]       vld,
        input logic [CDB_N*ROB_W-1:0] tags,
        input logic [CDB_N*XLEN-1:0]  vals
    );
        logic [XLEN:0] r;
        r = '0;
        for (int p = CDB_N - 1; p >= 0; p--)
            if (vld[p] && tags[p*ROB_W +: ROB_W] == tag)
                r = {1'b1, vals[p*XLEN +: XLEN]};
        return r;
    endfunction

    // k wins when no ready entry is older than it; age order makes this one-hot
    always_comb begin
        win      = '0;
        win_idx  = '0;
        free_idx = '0;
        for (int k = 0; k < RS_SIZE; k++)
            ready[k] = busy_q[k] & ent_q[k].rdy1 & ent_q[k].rdy2;
        for (int k = 0; k < RS_SIZE; k++) begin
            win[k] = ready[k] && ((older_q[k] & ready) == '0);
            if (win[k]) win_idx = IDX_W'(k);
        end
        for (int k = RS_SIZE - 1; k >= 0; k--)
            if (!busy_q[k]) free_idx = IDX_W'(k);
        alloc = bus.in_valid && !(&busy_q);
        load  = (!iss_valid_q || bus.iss_ready) && (ready != '0);
    end

    // incoming entry, with same-cycle CDB bypass for waiting operands
    always_comb begin
        byp1 = snoop(bus.in_Q1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        byp2 = snoop(bus.in_Q2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        new_ent.p.pc       = bus.in_pc;
        new_ent.p.is_short = bus.in_is_short;
        new_ent.p.op       = bus.in_op;
        new_ent.p.imm      = bus.in_imm;
        new_ent.p.qdest    = bus.in_Qdest;
        new_ent.p.v1       = bus.in_rdy1 ? bus.in_V1 : byp1[XLEN-1:0];
        new_ent.p.v2       = bus.in_rdy2 ? bus.in_V2 : byp2[XLEN-1:0];
        new_ent.rdy1       = bus.in_rdy1 | byp1[XLEN];
        new_ent.rdy2       = bus.in_rdy2 | byp2[XLEN];
        new_ent.q1         = bus.in_Q1;
        new_ent.q2         = bus.in_Q2;
    end

    always_comb begin
        ent_d       = ent_q;
        older_d     = older_q;
        busy_d      = busy_q;
        count_d     = count_q;
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        for (int k = 0; k < RS_SIZE; k++) begin
            wk1[k] = snoop(ent_q[k].q1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            wk2[k] = snoop(ent_q[k].q2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        end
        if (rdy_in && rob_clear) begin
            busy_d      = '0;
            count_d     = '0;
            iss_valid_d = 1'b0;
            for (int k = 0; k < RS_SIZE; k++) older_d[k] = '0;
        end else if (rdy_in) begin
            for (int k = 0; k < RS_SIZE; k++) begin
                if (busy_q[k] && !ent_q[k].rdy1 && wk1[k][XLEN]) begin
                    ent_d[k].rdy1 = 1'b1;
                    ent_d[k].p.v1 = wk1[k][XLEN-1:0];
                end
                if (busy_q[k] && !ent_q[k].rdy2 && wk2[k][XLEN]) begin
                    ent_d[k].rdy2 = 1'b1;
                    ent_d[k].p.v2 = wk2[k][XLEN-1:0];
                end
            end
            if (load) begin
                iss_d       = ent_q[win_idx].p;
                iss_valid_d = 1'b1;
                busy_d      = busy_q & ~win;
                for (int k = 0; k < RS_SIZE; k++) older_d[k] = older_d[k] & ~win;
            end else if (iss_valid_q && bus.iss_ready) begin
                iss_valid_d = 1'b0;
            end
            // free slot comes from registered busy: a slot freed now is reused next cycle
            if (alloc) begin
                ent_d[free_idx]  = new_ent;
                busy_d[free_idx] = 1'b1;
                for (int k = 0; k < RS_SIZE; k++) older_d[k][free_idx] = 1'b0;
                older_d[free_idx] = busy_q & ~(load ? win : '0);
            end
            count_d = count_q + CNT_W'(alloc) - CNT_W'(load);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ent_q       <= '{default: '0};
            older_q     <= '{default: '0};
            busy_q      <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else begin
            ent_q       <= ent_d;
            older_q     <= older_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
        end
    end

    assign bus.rs_full      = count_q >= FULL_TH;
    assign bus.count        = count_q;
    assign bus.iss_valid    = iss_valid_q;
    assign bus.iss_pc       = iss_q.pc;
    assign bus.iss_is_short = iss_q.is_short;
    assign bus.iss_op       = iss_q.op;
    assign bus.iss_imm      = iss_q.imm;
    assign bus.iss_V1       = iss_q.v1;
    assign bus.iss_V2       = iss_q.v2;
    assign bus.iss_Qdest    = iss_q.qdest;
endmodule
